// File: rtl/alu_mul_seq_pkg.sv
// Opcode constants shared between the shift-and-add sequencer and the ALU it drives.
// Only the subset this sequencer issues is listed here.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SHL  = 4'hd;
  localparam logic [3:0] ALU_ZERO = 4'hf;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-and-add multiplier sequencer that performs every add and every
// multiplicand shift through an external ALU with a one-cycle registered result.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [data_width-1:0] op_a,
  input  logic [data_width-1:0] op_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] product,
  output logic [data_width-1:0] alu_a,
  output logic [data_width-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [data_width-1:0] alu_r
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ADD_I,
    S_ADD_W,
    S_SHL_I,
    S_SHL_W,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [data_width-1:0] r_p;
  logic [data_width-1:0] r_m;
  logic [data_width-1:0] r_q;
  logic [data_width-1:0] r_product;
  logic                  w_q_zero;

  assign w_q_zero = (r_q == '0);
  assign product  = r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m <= op_a;
            r_q <= op_b;
            r_p <= '0;
          end
        end
        // Loading here makes the product already valid during the done pulse.
        S_CHECK: begin
          if (w_q_zero) begin
            r_product <= r_p;
          end
        end
        S_ADD_W: r_p <= alu_r;
        S_SHL_W: begin
          r_m <= alu_r;
          r_q <= r_q >> 1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_op       = ALU_ZERO;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_q_zero) begin
          w_state_next = S_DONE;
        end else if (r_q[0]) begin
          w_state_next = S_ADD_I;
        end else begin
          w_state_next = S_SHL_I;
        end
      end
      S_ADD_I: begin
        alu_a        = r_p;
        alu_b        = r_m;
        alu_op       = ALU_ADD;
        w_state_next = S_ADD_W;
      end
      S_ADD_W: w_state_next = S_SHL_I;
      S_SHL_I: begin
        alu_a        = r_m;
        alu_op       = ALU_SHL;
        w_state_next = S_SHL_W;
      end
      S_SHL_W: w_state_next = S_CHECK;
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural one-cycle registered ALU model.
module tb_alu_mul_seq;

  localparam int W = 32;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'hd;
  localparam logic [3:0] OP_ZERO = 4'hf;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] product;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_r = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] op_log[$];

  alu_mul_seq #(.data_width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r)
  );

  always #5 clk = ~clk;

  // ALU reference: registered result, SHL shifts A left by one.
  always @(posedge clk) begin
    case (alu_op)
      OP_ADD:  alu_r <= alu_a + alu_b;
      OP_SHL:  alu_r <= alu_a << 1;
      default: alu_r <= '0;
    endcase
  end

  always @(negedge clk) begin
    if (alu_op !== OP_ZERO) op_log.push_back(alu_op);
  end

  // Launch one transaction and return the done cycle (-1 on timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int limit,
                        output int cyc, output logic [W-1:0] prod);
    @(negedge clk);
    op_log.delete();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = -1;
    prod = 'x;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (done) begin
        cyc  = n;
        prod = product;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0 ||
        alu_op !== OP_ZERO || alu_a !== '0 || alu_b !== '0) begin
      n_errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b product=%h op=%h a=%h b=%h, required 1 0 0 0 f 0 0",
               ready, busy, done, product, alu_op, alu_a, alu_b);
    end
    rst = 1'b0;
    $display("test_reset: ready=%b busy=%b product=%h", ready, busy, product);
  endtask

  task automatic test_basic();
    int cyc;
    logic [W-1:0] prod;
    logic [3:0] exp_ops[5];
    exp_ops = '{OP_ADD, OP_SHL, OP_SHL, OP_ADD, OP_SHL};
    run_op(32'd3, 32'd5, 40, cyc, prod);
    n_checks++;
    if (cyc !== 15) begin
      n_errors++;
      $display("FAIL basic_latency: got %0d required 15", cyc);
    end
    n_checks++;
    if (prod !== 32'd15) begin
      n_errors++;
      $display("FAIL basic_product: got %h required %h", prod, 32'd15);
    end
    n_checks++;
    if (op_log.size() != 5) begin
      n_errors++;
      $display("FAIL basic_opcount: got %0d required 5", op_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (op_log[i] !== exp_ops[i]) begin
          n_errors++;
          $display("FAIL basic_opseq[%0d]: got %h required %h", i, op_log[i], exp_ops[i]);
        end
      end
    end
    $display("test_basic: 3*5 -> %h in %0d cycles, %0d alu ops", prod, cyc, op_log.size());
  endtask

  task automatic test_wrap();
    int cyc;
    logic [W-1:0] prod;
    run_op(32'hFFFF_FFFF, 32'd2, 40, cyc, prod);
    n_checks++;
    if (cyc !== 10) begin
      n_errors++;
      $display("FAIL wrap_latency: got %0d required 10", cyc);
    end
    n_checks++;
    if (prod !== 32'hFFFF_FFFE) begin
      n_errors++;
      $display("FAIL wrap_product: got %h required fffffffe", prod);
    end
    $display("test_wrap: ffffffff*2 -> %h in %0d cycles", prod, cyc);
  endtask

  task automatic test_allones_ignore();
    int cyc;
    @(negedge clk);
    op_log.delete();
    start = 1'b1;
    op_a  = 32'd1;
    op_b  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 20) begin
        start = 1'b1;
        op_a  = 32'd5;
        op_b  = 32'd3;
      end else if (n == 21) begin
        start = 1'b0;
        n_checks++;
        if (product !== 32'hFFFF_FFFE || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL ignore_midrun: product=%h busy=%b required fffffffe 1", product, busy);
        end
      end
      if (done) begin
        cyc = n;
        break;
      end
    end
    n_checks++;
    if (cyc !== 162) begin
      n_errors++;
      $display("FAIL allones_latency: got %0d required 162", cyc);
    end
    n_checks++;
    if (product !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL allones_product: got %h required ffffffff", product);
    end
    $display("test_allones_ignore: 1*ffffffff -> %h in %0d cycles", product, cyc);
  endtask

  task automatic test_zero();
    int cyc;
    logic [W-1:0] prod;
    run_op(32'h1234, 32'd0, 20, cyc, prod);
    n_checks++;
    if (cyc !== 2) begin
      n_errors++;
      $display("FAIL zero_latency: got %0d required 2", cyc);
    end
    n_checks++;
    if (prod !== '0) begin
      n_errors++;
      $display("FAIL zero_product: got %h required 0", prod);
    end
    n_checks++;
    if (op_log.size() != 0) begin
      n_errors++;
      $display("FAIL zero_noops: got %0d alu ops required 0", op_log.size());
    end
    $display("test_zero: 1234*0 -> %h in %0d cycles", prod, cyc);
  endtask

  task automatic test_back_to_back();
    int c1;
    int c2;
    logic [W-1:0] p1;
    logic [W-1:0] p2;
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd6;
    @(posedge clk);
    #1;
    op_a = 32'd9;
    op_b = 32'd9;
    c1 = -1;
    p1 = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        c1 = n;
        p1 = product;
        break;
      end
    end
    n_checks++;
    if (c1 !== 15 || p1 !== 32'd42) begin
      n_errors++;
      $display("FAIL b2b_first: cycles=%0d product=%h required 15 0000002a", c1, p1);
    end
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_idle_ready: got %b required 1", ready);
    end
    c2 = -1;
    p2 = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_checks++;
        if (ready !== 1'b0) begin
          n_errors++;
          $display("FAIL b2b_ready_drop: got %b required 0", ready);
        end
      end
      if (done) begin
        c2 = n;
        p2 = product;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (c2 !== 18 || p2 !== 32'd81) begin
      n_errors++;
      $display("FAIL b2b_second: cycles=%0d product=%h required 18 00000051", c2, p2);
    end
    $display("test_back_to_back: 7*6 -> %h (%0d), 9*9 -> %h (%0d)", p1, c1, p2, c2);
  endtask

  task automatic test_reset_midrun();
    int n_done;
    @(negedge clk);
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (alu_op !== OP_ADD) begin
      n_errors++;
      $display("FAIL midrun_add_issue: op=%h required 1", alu_op);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || product !== '0 || alu_op !== OP_ZERO) begin
      n_errors++;
      $display("FAIL midrun_reset: ready=%b busy=%b product=%h op=%h required 1 0 0 f",
               ready, busy, product, alu_op);
    end
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0 || ready !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_nodone: done pulses=%0d ready=%b required 0 1", n_done, ready);
    end
    $display("test_reset_midrun: ready=%b product=%h done pulses=%0d", ready, product, n_done);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_allones_ignore();
    test_zero();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
